// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path: state encoding,
// data-bit encodings, per-frame configuration and parity calculation.
package uart_pkg;

  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  // Widest data word parity_calc accepts; narrower words are zero-extended.
  localparam int unsigned PAR_MAX_W = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } tx_state_t;

  typedef struct packed {
    logic [1:0] dbits;
    logic       par_en;
    logic       par_odd;
    logic       stop2;
  } frame_cfg_t;

  function automatic logic [3:0] dbits_count(input logic [1:0] dbits);
    return 4'd5 + {2'b00, dbits};
  endfunction

  function automatic logic parity_calc(input logic [PAR_MAX_W-1:0] data,
                                       input logic [3:0]           nbits,
                                       input logic                 odd);
    logic p;
    p = odd;
    for (int unsigned i = 0; i < PAR_MAX_W; i++) begin
      if (i < 32'(nbits)) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding a tick-paced
// start/data/parity/stop serialiser, allowing gap-free back-to-back frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              baud_tick,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        cfg_dbits,
  input  logic              cfg_par_en,
  input  logic              cfg_par_odd,
  input  logic              cfg_stop2,
  output logic              tx,
  output logic              busy
);

  tx_state_t          r_state;
  logic [DATA_W-1:0]  r_hold_data;
  frame_cfg_t         r_hold_cfg;
  logic               r_hold_valid;
  logic [DATA_W-1:0]  r_shift;
  logic [3:0]         r_nbits;
  logic               r_par_en;
  logic               r_stop2;
  logic               r_par;
  logic [3:0]         r_bit_cnt;
  logic               r_stop_cnt;
  logic               r_tx;

  logic                 w_accept;
  logic                 w_load;
  logic                 w_stop_last;
  logic                 w_data_last;
  logic                 w_hold_par;
  logic [DATA_W-1:0]    w_in_masked;
  logic [PAR_MAX_W-1:0] w_hold_ext;

  assign w_accept    = in_valid && !r_hold_valid;
  assign w_stop_last = !r_stop2 || r_stop_cnt;
  assign w_data_last = (r_bit_cnt == (r_nbits - 4'd1));

  // Only registered hold_valid is looked at, so a same-cycle accept waits
  // for the following load point.
  assign w_load = baud_tick && r_hold_valid &&
                  ((r_state == S_IDLE) || ((r_state == S_STOP) && w_stop_last));

  always_comb begin
    w_in_masked = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (i < 32'(dbits_count(cfg_dbits))) w_in_masked[i] = in_data[i];
    end
  end

  always_comb begin
    w_hold_ext = '0;
    w_hold_ext[DATA_W-1:0] = r_hold_data;
  end

  assign w_hold_par = parity_calc(w_hold_ext, dbits_count(r_hold_cfg.dbits),
                                  r_hold_cfg.par_odd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
      r_hold_cfg   <= '0;
    end else if (w_load) begin
      r_hold_valid <= 1'b0;
    end else if (w_accept) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= w_in_masked;
      r_hold_cfg   <= '{dbits: cfg_dbits, par_en: cfg_par_en,
                        par_odd: cfg_par_odd, stop2: cfg_stop2};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tx       <= 1'b1;
      r_shift    <= '0;
      r_nbits    <= 4'd8;
      r_par_en   <= 1'b0;
      r_stop2    <= 1'b0;
      r_par      <= 1'b0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
    end else if (baud_tick) begin
      if (w_load) begin
        r_shift  <= r_hold_data;
        r_nbits  <= dbits_count(r_hold_cfg.dbits);
        r_par_en <= r_hold_cfg.par_en;
        r_stop2  <= r_hold_cfg.stop2;
        r_par    <= w_hold_par;
        r_tx     <= 1'b0;
        r_state  <= S_START;
      end else begin
        unique case (r_state)
          S_START: begin
            r_tx      <= r_shift[0];
            r_bit_cnt <= '0;
            r_state   <= S_DATA;
          end
          S_DATA: begin
            if (w_data_last) begin
              r_stop_cnt <= 1'b0;
              if (r_par_en) begin
                r_tx    <= r_par;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          S_PARITY: begin
            r_tx       <= 1'b1;
            r_stop_cnt <= 1'b0;
            r_state    <= S_STOP;
          end
          S_STOP: begin
            if (!w_stop_last) begin
              r_stop_cnt <= 1'b1;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end
          end
          S_IDLE: begin
            r_tx <= 1'b1;
          end
          default: begin
            r_tx    <= 1'b1;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign tx       = r_tx;
  assign in_ready = !r_hold_valid;
  assign busy     = (r_state != S_IDLE) || r_hold_valid;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: randomized frames checked bit-by-bit against a
// frame-level reference model, plus back-to-back, hold-full and reset cases.
module tb_uart_tx;

  logic       clk;
  logic       rst_n;
  logic       baud_tick;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] cfg_dbits;
  logic       cfg_par_en;
  logic       cfg_par_odd;
  logic       cfg_stop2;
  logic       tx;
  logic       busy;

  int unsigned cyc;
  int          total;
  int          passed;

  uart_tx #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_tick  (baud_tick),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cfg_dbits  (cfg_dbits),
    .cfg_par_en (cfg_par_en),
    .cfg_par_odd(cfg_par_odd),
    .cfg_stop2  (cfg_stop2),
    .tx         (tx),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-cycle tick every 10 clocks, driven away from the rising edge.
  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (9) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
    $fatal(1);
  end

  // Reference model: frame = start 0, n data bits LSB first, optional parity, 1 or 2 stops.
  function automatic int frame_len(logic [1:0] db, logic pe, logic s2);
    return 1 + (5 + int'(db)) + int'(pe) + 1 + int'(s2);
  endfunction

  function automatic logic exp_bit(logic [7:0] d, logic [1:0] db, logic pe,
                                   logic po, int k);
    int         n;
    logic [7:0] mask;
    n    = 5 + int'(db);
    mask = 8'((9'd1 << n) - 9'd1);
    if (k == 0) return 1'b0;
    if (k <= n) return d[k-1];
    if (pe && k == n + 1) return (($countones(d & mask) % 2) == 1) ^ po;
    return 1'b1;
  endfunction

  task automatic send(input string name, input logic [7:0] d, input logic [1:0] db,
                      input logic pe, input logic po, input logic s2);
    int w;
    w           = 0;
    in_data     = d;
    cfg_dbits   = db;
    cfg_par_en  = pe;
    cfg_par_odd = po;
    cfg_stop2   = s2;
    in_valid    = 1'b1;
    while (in_ready !== 1'b1 && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (in_ready !== 1'b1) begin
      total++;
      $display("FAIL %s accept: in_ready=%b after %0d cycles, required 1", name, in_ready, w);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    // Scramble inputs right after the accept; the held frame must be unaffected.
    in_valid    = 1'b0;
    in_data     = ~d;
    cfg_dbits   = ~db;
    cfg_par_en  = ~pe;
    cfg_par_odd = ~po;
    cfg_stop2   = ~s2;
    total++;
    if (in_ready !== 1'b0)
      $display("FAIL %s ready_fall: in_ready=%b, required 0", name, in_ready);
    else passed++;
  endtask

  task automatic check_frame(input string name, input logic [7:0] d, input logic [1:0] db,
                             input logic pe, input logic po, input logic s2,
                             output int unsigned start_cyc);
    int   w;
    int   len;
    logic e;
    w         = 0;
    len       = frame_len(db, pe, s2);
    start_cyc = 0;
    while (tx !== 1'b0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (tx !== 1'b0) begin
      $display("FAIL %s start: tx=%b after %0d cycles, required start bit 0", name, tx, w);
      return;
    end
    passed++;
    start_cyc = cyc;
    repeat (4) @(negedge clk);
    for (int k = 0; k < len; k++) begin
      if (k > 0) repeat (10) @(negedge clk);
      e = exp_bit(d, db, pe, po, k);
      total++;
      if (tx !== e)
        $display("FAIL %s bit%0d: tx=%b, required %b (data=%h cfg=%b%b%b%b)",
                 name, k, tx, e, d, db, pe, po, s2);
      else passed++;
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    cfg_dbits   = 2'b11;
    cfg_par_en  = 1'b0;
    cfg_par_odd = 1'b0;
    cfg_stop2   = 1'b0;
    repeat (3) @(negedge clk);
    total += 3;
    if (tx !== 1'b1) $display("FAIL reset_tx: tx=%b, required 1", tx); else passed++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready: in_ready=%b, required 1", in_ready); else passed++;
    if (busy !== 1'b0) $display("FAIL reset_busy: busy=%b, required 0", busy); else passed++;
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    total += 3;
    if (tx !== 1'b1) $display("FAIL idle_tick_tx: tx=%b, required 1", tx); else passed++;
    if (in_ready !== 1'b1) $display("FAIL idle_tick_ready: in_ready=%b, required 1", in_ready); else passed++;
    if (busy !== 1'b0) $display("FAIL idle_tick_busy: busy=%b, required 0", busy); else passed++;
  endtask

  task automatic test_8n1();
    int unsigned s;
    fork
      send("8n1", 8'hA5, 2'b11, 1'b0, 1'b0, 1'b0);
      check_frame("8n1", 8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, s);
    join
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b1) $display("FAIL 8n1_busy_hold: busy=%b, required 1", busy); else passed++;
    @(negedge clk);
    total += 3;
    if (busy !== 1'b0) $display("FAIL 8n1_busy_fall: busy=%b, required 0", busy); else passed++;
    if (tx !== 1'b1) $display("FAIL 8n1_idle_tx: tx=%b, required 1", tx); else passed++;
    if (in_ready !== 1'b1) $display("FAIL 8n1_idle_ready: in_ready=%b, required 1", in_ready); else passed++;
  endtask

  task automatic test_7e2();
    int unsigned s;
    fork
      send("7e2", 8'h41, 2'b10, 1'b1, 1'b0, 1'b1);
      check_frame("7e2", 8'h41, 2'b10, 1'b1, 1'b0, 1'b1, s);
    join
    repeat (10) @(negedge clk);
  endtask

  task automatic test_5o1();
    int unsigned s;
    fork
      send("5o1", 8'hFF, 2'b00, 1'b1, 1'b1, 1'b0);
      check_frame("5o1", 8'hFF, 2'b00, 1'b1, 1'b1, 1'b0, s);
    join
    repeat (10) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int unsigned s1;
    int unsigned s2;
    fork
      begin
        send("b2b_a", 8'h55, 2'b11, 1'b0, 1'b0, 1'b0);
        send("b2b_b", 8'h0F, 2'b11, 1'b0, 1'b0, 1'b0);
      end
      begin
        check_frame("b2b_a", 8'h55, 2'b11, 1'b0, 1'b0, 1'b0, s1);
        total++;
        if (in_ready !== 1'b0)
          $display("FAIL b2b_ready_held: in_ready=%b, required 0", in_ready);
        else passed++;
        check_frame("b2b_b", 8'h0F, 2'b11, 1'b0, 1'b0, 1'b0, s2);
        total++;
        if (s2 - s1 != 100)
          $display("FAIL b2b_gap: start-to-start=%0d cycles, required 100", s2 - s1);
        else passed++;
      end
    join
    repeat (10) @(negedge clk);
  endtask

  task automatic run_stream(input string name, input int cnt);
    logic [7:0]  d  [16];
    logic [1:0]  db [16];
    logic        pe [16];
    logic        po [16];
    logic        s2 [16];
    int unsigned st [16];
    for (int i = 0; i < cnt; i++) begin
      d[i]  = 8'($urandom);
      db[i] = 2'($urandom_range(0, 3));
      pe[i] = 1'($urandom_range(0, 1));
      po[i] = 1'($urandom_range(0, 1));
      s2[i] = 1'($urandom_range(0, 1));
    end
    fork
      for (int i = 0; i < cnt; i++) begin
        if (i == 2) begin
          total++;
          if (in_ready !== 1'b0)
            $display("FAIL %s hold_full: in_ready=%b, required 0", name, in_ready);
          else passed++;
        end
        send(name, d[i], db[i], pe[i], po[i], s2[i]);
      end
      for (int j = 0; j < cnt; j++) begin
        check_frame(name, d[j], db[j], pe[j], po[j], s2[j], st[j]);
        if (j > 0) begin
          total++;
          if (st[j] - st[j-1] != 32'(10 * frame_len(db[j-1], pe[j-1], s2[j-1])))
            $display("FAIL %s gap%0d: start-to-start=%0d cycles, required %0d",
                     name, j, st[j] - st[j-1], 10 * frame_len(db[j-1], pe[j-1], s2[j-1]));
          else passed++;
        end
      end
    join
    repeat (15) @(negedge clk);
  endtask

  task automatic test_hold_full();
    run_stream("hold_full", 3);
  endtask

  task automatic test_random();
    run_stream("random", 10);
  endtask

  task automatic test_reset_mid();
    logic [7:0]  d1;
    logic [7:0]  d3;
    int unsigned s;
    bit          saw_start;
    d1 = 8'($urandom);
    d3 = 8'($urandom);
    send("rst_a", d1, 2'b11, 1'b0, 1'b0, 1'b0);
    send("rst_b", 8'($urandom), 2'b11, 1'b0, 1'b0, 1'b0);
    repeat (43) @(negedge clk);
    total++;
    if (tx !== d1[3]) $display("FAIL rst_pre_bit3: tx=%b, required %b", tx, d1[3]); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total += 3;
    if (tx !== 1'b1) $display("FAIL rst_async_tx: tx=%b, required 1", tx); else passed++;
    if (in_ready !== 1'b1) $display("FAIL rst_async_ready: in_ready=%b, required 1", in_ready); else passed++;
    if (busy !== 1'b0) $display("FAIL rst_async_busy: busy=%b, required 0", busy); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    saw_start = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) saw_start = 1'b1;
    end
    total++;
    if (saw_start || busy !== 1'b0)
      $display("FAIL rst_discard: line activity=%b busy=%b, required 0 and 0", saw_start, busy);
    else passed++;
    fork
      send("rst_after", d3, 2'b11, 1'b0, 1'b0, 1'b0);
      check_frame("rst_after", d3, 2'b11, 1'b0, 1'b0, 1'b0, s);
    join
    repeat (10) @(negedge clk);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_8n1();
    test_7e2();
    test_5o1();
    test_back_to_back();
    test_hold_full();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
